ltc2324_capture_seq: RTL

Sequencer for the LTC2324-16 front end on `adc_clk`. Drives `adc_CNV` and `adc_SCK` and captures all four 16-bit SDO lanes per conversion. Packs each conversion into 8 bytes and writes them into the write side of the DMA async FIFO. Runs a frame of `sample_len` conversions per `sample_start`, and replaces the synthetic byte counter currently feeding that FIFO.

---
 rtl/ltc2324_pkg.sv | 17 +
 rtl/ltc2324_lane_shift.sv | 39 +++
 rtl/ltc2324_capture_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ltc2324_pkg.sv
// Shared types and sizes for the LTC2324-16 capture sequencer.
package ltc2324_pkg;

  localparam int unsigned LTC_BITS         = 16;
  localparam int unsigned LTC_LANES        = 4;
  localparam int unsigned BYTES_PER_SAMPLE = 8;
  localparam int unsigned WORD_W           = LTC_BITS * LTC_LANES;

  typedef enum logic [2:0] {
    IDLE,
    CNV_HI,
    CONV_WAIT,
    SHIFT,
    EMIT
  } state_e;

endpackage

// File: rtl/ltc2324_lane_shift.sv
// Four MSB-first serial-to-parallel lanes with a shared shift enable and clear.
module ltc2324_lane_shift
  import ltc2324_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 shift_en_i,
  input  logic [LTC_LANES-1:0] sdo_i,
  output logic [WORD_W-1:0]    word_o
);

  logic [LTC_LANES-1:0][LTC_BITS-1:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    if (clr_i) begin
      lane_d = '0;
    end else if (shift_en_i) begin
      for (int l = 0; l < int'(LTC_LANES); l++) begin
        lane_d[l] = {lane_q[l][LTC_BITS-2:0], sdo_i[l]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lane_q <= '0;
    else        lane_q <= lane_d;
  end

  // Lane 0 (channel 1) lands in the most-significant halfword.
  always_comb begin
    word_o = '0;
    for (int l = 0; l < int'(LTC_LANES); l++) begin
      word_o[WORD_W-1-l*LTC_BITS -: LTC_BITS] = lane_q[l];
    end
  end

endmodule

// File: rtl/ltc2324_capture_seq.sv
// LTC2324-16 conversion/readout sequencer feeding 8 bytes per conversion into the DMA FIFO.
module ltc2324_capture_seq
  import ltc2324_pkg::*;
#(
  parameter int unsigned CNV_HIGH_CYC  = 2,
  parameter int unsigned CONV_WAIT_CYC = 45,
  parameter int unsigned SCK_HALF_CYC  = 1
) (
  input  logic        adc_clk,
  input  logic        adc_rst_n,
  input  logic        sample_start,
  input  logic [31:0] sample_len,
  output logic        adc_CNV,
  output logic        adc_SCK,
  input  logic        adc_SDO1,
  input  logic        adc_SDO2,
  input  logic        adc_SDO3,
  input  logic        adc_SDO4,
  input  logic        fifo_full,
  output logic [7:0]  fifo_din,
  output logic        fifo_wr_en,
  output logic        st_clr,
  output logic        done
);

  localparam logic [31:0] CNV_LAST    = 32'(CNV_HIGH_CYC - 1);
  localparam logic [31:0] WAIT_LAST   = 32'(CONV_WAIT_CYC - 1);
  localparam logic [31:0] SCK_HI_LAST = 32'(SCK_HALF_CYC - 1);
  localparam logic [31:0] SCK_PER_LAST = 32'(2 * SCK_HALF_CYC - 1);
  localparam logic [3:0]  BIT_LAST    = 4'(LTC_BITS - 1);
  localparam logic [2:0]  BYTE_LAST   = 3'(BYTES_PER_SAMPLE - 1);

  state_e      state_q, state_d;
  logic [31:0] phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [31:0] samp_q, samp_d;
  logic [31:0] len_q, len_d;
  logic        cnv_q, cnv_d;
  logic        sck_q, sck_d;
  logic        st_clr_q, st_clr_d;
  logic        done_q, done_d;
  logic        shift_en, lane_clr, wr_c;

  logic [WORD_W-1:0]                      word;
  logic [BYTES_PER_SAMPLE-1:0][7:0]       word_bytes;

  ltc2324_lane_shift u_lanes (
    .clk        (adc_clk),
    .rst_n      (adc_rst_n),
    .clr_i      (lane_clr),
    .shift_en_i (shift_en),
    .sdo_i      ({adc_SDO4, adc_SDO3, adc_SDO2, adc_SDO1}),
    .word_o     (word)
  );

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      samp_q   <= '0;
      len_q    <= '0;
      cnv_q    <= 1'b0;
      sck_q    <= 1'b0;
      st_clr_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      samp_q   <= samp_d;
      len_q    <= len_d;
      cnv_q    <= cnv_d;
      sck_q    <= sck_d;
      st_clr_q <= st_clr_d;
      done_q   <= done_d;
    end
  end

  // CNV/SCK are registered from the next state so each phase is exact to the cycle.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    samp_d   = samp_q;
    len_d    = len_q;
    cnv_d    = 1'b0;
    sck_d    = 1'b0;
    st_clr_d = st_clr_q;
    done_d   = 1'b0;
    shift_en = 1'b0;
    lane_clr = 1'b0;
    wr_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_start) begin
          if (sample_len != 32'd0) begin
            len_d    = sample_len;
            state_d  = CNV_HI;
            phase_d  = '0;
            cnv_d    = 1'b1;
            st_clr_d = 1'b1;
            lane_clr = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      CNV_HI: begin
        if (phase_q == CNV_LAST) begin
          state_d = CONV_WAIT;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 32'd1;
          cnv_d   = 1'b1;
        end
      end
      CONV_WAIT: begin
        if (phase_q == WAIT_LAST) begin
          state_d = SHIFT;
          phase_d = '0;
          bit_d   = '0;
          sck_d   = 1'b1;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      SHIFT: begin
        // Capture on the edge that drops SCK, i.e. the end of the high half.
        shift_en = (phase_q == SCK_HI_LAST);
        if (phase_q == SCK_PER_LAST) begin
          phase_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = EMIT;
            byte_d  = '0;
          end else begin
            bit_d = bit_q + 4'd1;
            sck_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + 32'd1;
          sck_d   = (phase_q < SCK_HI_LAST);
        end
      end
      EMIT: begin
        wr_c = !fifo_full;
        if (wr_c) begin
          if (byte_q == BYTE_LAST) begin
            byte_d = '0;
            if (samp_q + 32'd1 == len_q) begin
              state_d  = IDLE;
              st_clr_d = 1'b0;
              done_d   = 1'b1;
              samp_d   = '0;
            end else begin
              samp_d   = samp_q + 32'd1;
              state_d  = CNV_HI;
              phase_d  = '0;
              cnv_d    = 1'b1;
              lane_clr = 1'b1;
            end
          end else begin
            byte_d = byte_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_bytes = word;
  assign adc_CNV    = cnv_q;
  assign adc_SCK    = sck_q;
  assign st_clr     = st_clr_q;
  assign done       = done_q;
  assign fifo_wr_en = wr_c;
  assign fifo_din   = (state_q == EMIT) ? word_bytes[BYTE_LAST - byte_q] : 8'h00;

endmodule
